// File: rtl/shift_split.sv
// Splits a packed 64-bit word stream into 1..64-bit LSB-first segments; segment appears one clock after grant.
// Word input stalls while more than 64 bits are buffered or after the last word; requests stall until enough bits are held.
module shift_split #(
    parameter int WORD_W = 64,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    input  logic              word_last,
    input  logic [6:0]        last_bits,
    output logic              word_ready,
    input  logic              req_valid,
    input  logic [6:0]        req_bits,
    output logic              req_ready,
    output logic [WORD_W-1:0] data_out,
    output logic [6:0]        out_bits,
    output logic              data_out_valid,
    output logic              short_seg,
    output logic              req_err,
    output logic              done,
    input  logic              msg_clr
);

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    state_t                  state_q, state_d;
    logic [2*WORD_W-1:0]     buf_q, buf_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    fin_q, fin_d;
    logic [WORD_W-1:0]       data_q, data_d;
    logic [6:0]              obits_q, obits_d;
    logic                    dvld_q, dvld_d;
    logic                    short_q, short_d;
    logic                    err_q, err_d;

    logic                    n_ok;
    logic                    take;
    logic                    accept;
    logic [6:0]              take_bits;
    logic [CNT_W-1:0]        cnt_after;
    logic [CNT_W-1:0]        add_bits;
    logic [2*WORD_W-1:0]     ins;

    // Ones in the low b bits; b in 0..64.
    function automatic logic [WORD_W-1:0] seg_mask(input logic [6:0] b);
        seg_mask = (b == 7'd0) ? '0 : ({WORD_W{1'b1}} >> (7'd64 - b));
    endfunction

    assign n_ok       = (req_bits != 7'd0) && (req_bits <= 7'd64);
    assign word_ready = (state_q == RUN) && (cnt_q <= 8'd64);
    assign req_ready  = req_valid && n_ok && (state_q != DONE) &&
                        ((cnt_q >= {1'b0, req_bits}) || (fin_q && (cnt_q != '0)));
    assign take       = req_ready;
    assign accept     = word_valid && word_ready;

    assign take_bits  = !take ? 7'd0 :
                        (cnt_q >= {1'b0, req_bits}) ? req_bits : cnt_q[6:0];
    assign cnt_after  = cnt_q - {1'b0, take_bits};

    // A zero or out-of-range last_bits on the final word is treated as a full word.
    assign add_bits   = (!word_last || last_bits == 7'd0 || last_bits > 7'd64) ? 8'd64
                                                                               : {1'b0, last_bits};
    assign ins        = {{WORD_W{1'b0}}, word_in & seg_mask(add_bits[6:0])} << cnt_after;

    always_comb begin
        buf_d   = (buf_q >> take_bits) | (accept ? ins : '0);
        cnt_d   = cnt_after + (accept ? add_bits : '0);
        data_d  = take ? (buf_q[WORD_W-1:0] & seg_mask(take_bits)) : '0;
        obits_d = take_bits;
        dvld_d  = take;
        short_d = take && (cnt_q < {1'b0, req_bits});
        err_d   = req_valid && !n_ok;
    end

    always_comb begin
        state_d = state_q;
        fin_d   = fin_q;
        case (state_q)
            RUN: begin
                if (accept && word_last) begin
                    state_d = DRAIN;
                    fin_d   = 1'b1;
                end
            end
            DRAIN: begin
                if (take && cnt_after == '0) state_d = DONE;
            end
            DONE: begin
                if (msg_clr) begin
                    state_d = RUN;
                    fin_d   = 1'b0;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            buf_q   <= '0;
            cnt_q   <= '0;
            fin_q   <= 1'b0;
            data_q  <= '0;
            obits_q <= '0;
            dvld_q  <= 1'b0;
            short_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            fin_q   <= fin_d;
            data_q  <= data_d;
            obits_q <= obits_d;
            dvld_q  <= dvld_d;
            short_q <= short_d;
            err_q   <= err_d;
        end
    end

    assign data_out       = data_q;
    assign out_bits       = obits_q;
    assign data_out_valid = dvld_q;
    assign short_seg      = short_q;
    assign req_err        = err_q;
    assign done           = (state_q == DONE);

endmodule

// File: tb/tb_shift_split.sv
// Directed bench for shift_split: expected segments are queued at grant time and checked when data_out_valid pulses.
module tb_shift_split;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] word_in = '0;
    logic        word_valid = 1'b0;
    logic        word_last = 1'b0;
    logic [6:0]  last_bits = '0;
    logic        word_ready;
    logic        req_valid = 1'b0;
    logic [6:0]  req_bits = '0;
    logic        req_ready;
    logic [63:0] data_out;
    logic [6:0]  out_bits;
    logic        data_out_valid;
    logic        short_seg;
    logic        req_err;
    logic        done;
    logic        msg_clr = 1'b0;

    typedef struct packed {
        logic [63:0] d;
        logic [6:0]  b;
        logic        s;
    } exp_t;

    exp_t        sb[$];
    int          n_total = 0;
    int          n_pass  = 0;
    logic [63:0] ex;
    logic [63:0] w;

    shift_split dut (
        .clk(clk), .rst(rst),
        .word_in(word_in), .word_valid(word_valid), .word_last(word_last),
        .last_bits(last_bits), .word_ready(word_ready),
        .req_valid(req_valid), .req_bits(req_bits), .req_ready(req_ready),
        .data_out(data_out), .out_bits(out_bits), .data_out_valid(data_out_valid),
        .short_seg(short_seg), .req_err(req_err), .done(done), .msg_clr(msg_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        if (rst && data_out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("seg_data", data_out, e.d);
                chk("seg_bits", {57'd0, out_bits}, {57'd0, e.b});
                chk("seg_short", {63'd0, short_seg}, {63'd0, e.s});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [63:0] d, input logic last, input logic [6:0] lb);
        bit ok = 0;
        word_in = d; word_last = last; last_bits = lb; word_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            #1;
            if (word_ready) ok = 1;
            step();
        end
        word_valid = 1'b0; word_last = 1'b0;
        if (!ok) chk("word_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_req(input logic [6:0] n, input logic [63:0] d, input logic [6:0] b, input logic s);
        bit ok = 0;
        req_valid = 1'b1; req_bits = n;
        for (int i = 0; i < 50 && !ok; i++) begin
            #1;
            if (req_ready) begin
                sb.push_back(exp_t'{d, b, s});
                ok = 1;
            end
            step();
        end
        req_valid = 1'b0;
        if (!ok) chk("req_timeout", 64'd0, 64'd1);
    endtask

    task automatic clear_msg();
        msg_clr = 1'b1;
        step();
        msg_clr = 1'b0;
        #1;
        chk("clr_done", {63'd0, done}, 64'd0);
        chk("clr_word_ready", {63'd0, word_ready}, 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        // Reset state
        #1 rst = 1'b0;
        #2;
        chk("rst_data_out", data_out, 64'd0);
        chk("rst_out_bits", {57'd0, out_bits}, 64'd0);
        chk("rst_valid", {63'd0, data_out_valid}, 64'd0);
        chk("rst_short", {63'd0, short_seg}, 64'd0);
        chk("rst_err", {63'd0, req_err}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_word_ready", {63'd0, word_ready}, 64'd1);
        step(); step();
        rst = 1'b1;
        step();

        // Fixed-length split: 16 bytes LSB-first
        send_word(64'hFEDCBA9876543210, 1'b0, 7'd0);
        send_word(64'h0123456789ABCDEF, 1'b1, 7'd64);
        for (int i = 0; i < 16; i++) begin
            w  = (i < 8) ? 64'hFEDCBA9876543210 : 64'h0123456789ABCDEF;
            ex = (w >> (8 * (i % 8))) & 64'hFF;
            do_req(7'd8, ex, 7'd8, 1'b0);
        end
        chk("t1_done", {63'd0, done}, 64'd1);
        chk("t1_word_ready", {63'd0, word_ready}, 64'd0);
        clear_msg();

        // Word-spanning segments
        send_word(64'hFFFFFFFF00000000, 1'b0, 7'd0);
        send_word(64'h123456789ABCDEF0, 1'b1, 7'd64);
        do_req(7'd40, 64'h000000FF00000000, 7'd40, 1'b0);
        do_req(7'd40, 64'h000000DEF0FFFFFF, 7'd40, 1'b0);
        do_req(7'd48, 64'h0000123456789ABC, 7'd48, 1'b0);
        chk("t2_done", {63'd0, done}, 64'd1);
        clear_msg();

        // Short final segment; bits above last_bits must be masked on entry
        send_word(64'hFFFFFFFFFFFFFFFF, 1'b1, 7'd10);
        do_req(7'd8, 64'hFF, 7'd8, 1'b0);
        do_req(7'd8, 64'h3, 7'd2, 1'b1);
        chk("t3_done", {63'd0, done}, 64'd1);
        clear_msg();

        // Back-pressure at 128 bits, then same-cycle accept and extract
        send_word(64'hA1A2A3A4A5A6A7A8, 1'b0, 7'd0);
        send_word(64'hB1B2B3B4B5B6B7B8, 1'b0, 7'd0);
        #1;
        chk("bp_full_word_ready", {63'd0, word_ready}, 64'd0);
        word_in = 64'hC1C2C3C4C5C6C7C8; word_last = 1'b0; word_valid = 1'b1;
        req_valid = 1'b1; req_bits = 7'd64;
        #1;
        chk("bp_full_ready_hold", {63'd0, word_ready}, 64'd0);
        chk("bp_req_ready", {63'd0, req_ready}, 64'd1);
        sb.push_back(exp_t'{64'hA1A2A3A4A5A6A7A8, 7'd64, 1'b0});
        step();
        req_valid = 1'b0;
        #1;
        chk("bp_after_req_word_ready", {63'd0, word_ready}, 64'd1);
        step();
        word_valid = 1'b0;
        #1;
        chk("bp_refull_word_ready", {63'd0, word_ready}, 64'd0);
        do_req(7'd64, 64'hB1B2B3B4B5B6B7B8, 7'd64, 1'b0);
        #1;
        chk("bp_half_word_ready", {63'd0, word_ready}, 64'd1);
        word_in = 64'hD1D2D3D4D5D6D7D8; word_last = 1'b1; last_bits = 7'd64; word_valid = 1'b1;
        req_valid = 1'b1; req_bits = 7'd64;
        #1;
        chk("bp_same_word_ready", {63'd0, word_ready}, 64'd1);
        chk("bp_same_req_ready", {63'd0, req_ready}, 64'd1);
        sb.push_back(exp_t'{64'hC1C2C3C4C5C6C7C8, 7'd64, 1'b0});
        step();
        word_valid = 1'b0; word_last = 1'b0; req_valid = 1'b0;
        do_req(7'd64, 64'hD1D2D3D4D5D6D7D8, 7'd64, 1'b0);
        chk("t4_done", {63'd0, done}, 64'd1);
        clear_msg();

        // Illegal request lengths
        send_word(64'h0F1E2D3C4B5A6978, 1'b0, 7'd0);
        req_valid = 1'b1; req_bits = 7'd0;
        #1;
        chk("err0_req_ready", {63'd0, req_ready}, 64'd0);
        step();
        chk("err0_pulse", {63'd0, req_err}, 64'd1);
        req_bits = 7'd65;
        #1;
        chk("err65_req_ready", {63'd0, req_ready}, 64'd0);
        step();
        chk("err65_pulse", {63'd0, req_err}, 64'd1);
        req_valid = 1'b0;
        step();
        chk("err_cleared", {63'd0, req_err}, 64'd0);
        do_req(7'd32, 64'h4B5A6978, 7'd32, 1'b0);

        // Reset mid-DRAIN
        send_word(64'hFFFFFFFFFFFFBEEF, 1'b1, 7'd16);
        req_valid = 1'b1; req_bits = 7'd8;
        #1;
        chk("drain_req_ready", {63'd0, req_ready}, 64'd1);
        step();
        req_valid = 1'b0;
        chk("drain_valid", {63'd0, data_out_valid}, 64'd1);
        chk("drain_data", data_out, 64'h3C);
        rst = 1'b0;
        #1;
        chk("mid_rst_data_out", data_out, 64'd0);
        chk("mid_rst_out_bits", {57'd0, out_bits}, 64'd0);
        chk("mid_rst_valid", {63'd0, data_out_valid}, 64'd0);
        chk("mid_rst_short", {63'd0, short_seg}, 64'd0);
        chk("mid_rst_done", {63'd0, done}, 64'd0);
        chk("mid_rst_word_ready", {63'd0, word_ready}, 64'd1);
        step();
        rst = 1'b1;
        step();

        // New message after reset starts from an empty buffer
        send_word(64'hFFFFFFFFFFFFFF5A, 1'b1, 7'd8);
        do_req(7'd8, 64'h5A, 7'd8, 1'b0);
        chk("t6_done", {63'd0, done}, 64'd1);

        @(negedge clk);
        #1;
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
